sumador_pipe_param: RTL and testbench

- Parametrised, pipelined adder/subtractor. Generalises the team's registered 16-bit adder in operand width and pipeline depth.
- Adds subtract mode, signed overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits on streaming datapaths where a wide carry chain must be split across cycles to meet timing.

---
 rtl/sumador_pipe_param.sv | 149 ++++++++++++++
 tb/tb_sumador_pipe_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sumador_pipe_param.sv
// Pipelined adder/subtractor: WIDTH-bit operands, carry chain split into STAGES segments.
// Define SUMADOR_SAT_EN to clamp signed-overflowing results in the last stage.
module sumador_pipe_param #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, ovf_q, zero_q;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && rst_n;

  // Subtract folds into addition: a + ~b + !borrow_in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~carry_in : carry_in;

  // Intermediate stages 0..STAGES-2. Each keeps only the operand bits still
  // to be summed (ai/bi shrink by SEG per stage) and the partial sum so far.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stg
    localparam int RW = WIDTH - (k + 1) * SEG;
    localparam int PW = (k + 1) * SEG;

    logic [RW+SEG-1:0] ai, bi;
    logic              ci, vi;
    logic [SEG:0]      seg_sum;
    logic [PW-1:0]     s_d;
    logic [RW-1:0]     a_q, b_q;
    logic [PW-1:0]     s_q;
    logic              c_q, v_q;

    assign seg_sum = {1'b0, ai[SEG-1:0]} + {1'b0, bi[SEG-1:0]} + {{SEG{1'b0}}, ci};

    if (k == 0) begin : g_in
      assign ai  = a;
      assign bi  = b_eff;
      assign ci  = c_eff;
      assign vi  = in_valid;
      assign s_d = seg_sum[SEG-1:0];
    end else begin : g_in
      assign ai  = g_stg[k-1].a_q;
      assign bi  = g_stg[k-1].b_q;
      assign ci  = g_stg[k-1].c_q;
      assign vi  = g_stg[k-1].v_q;
      assign s_d = {seg_sum[SEG-1:0], g_stg[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        a_q <= ai[RW+SEG-1:SEG];
        b_q <= bi[RW+SEG-1:SEG];
        s_q <= s_d;
        c_q <= seg_sum[SEG];
        v_q <= vi;
      end
    end
  end

  // Last stage: top segment, flags, optional clamp, output registers.
  logic [SEG-1:0]   la, lb;
  logic             lc, lv;
  logic [SEG:0]     top;
  logic [WIDTH-1:0] raw_sum, fin_sum;
  logic             ovf;

  assign top = {1'b0, la} + {1'b0, lb} + {{SEG{1'b0}}, lc};

  if (STAGES == 1) begin : g_last
    assign la      = a;
    assign lb      = b_eff;
    assign lc      = c_eff;
    assign lv      = in_valid;
    assign raw_sum = top[SEG-1:0];
  end else begin : g_last
    assign la      = g_stg[STAGES-2].a_q;
    assign lb      = g_stg[STAGES-2].b_q;
    assign lc      = g_stg[STAGES-2].c_q;
    assign lv      = g_stg[STAGES-2].v_q;
    assign raw_sum = {top[SEG-1:0], g_stg[STAGES-2].s_q};
  end

  // Carry into the MSB is recovered from the MSB sum bit.
  assign ovf = (la[SEG-1] ^ lb[SEG-1] ^ top[SEG-1]) ^ top[SEG];

`ifdef SUMADOR_SAT_EN
  // On overflow both operands share a sign, so a's MSB gives the true sign.
  always_comb begin
    fin_sum = raw_sum;
    if (ovf)
      fin_sum = la[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign fin_sum = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= lv;
      if (lv) begin
        sum_q   <= fin_sum;
        carry_q <= top[SEG];
        ovf_q   <= ovf;
        zero_q  <= (fin_sum == '0);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sumador_pipe_param.sv
// Directed bench for sumador_pipe_param: main DUT 32/4, plus 32/1 and 8/8 instances.
module tb_sumador_pipe_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, carry_in, sub;
  logic [31:0] a, b;

  logic        in_ready, out_valid, carry_out, overflow, zero;
  logic [31:0] sum;
  logic        rdy1, v1, c1, o1, z1;
  logic [31:0] sum1;
  logic        rdy8, v8, c8, o8, z8;
  logic [7:0]  sum8;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sumador_pipe_param #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .zero(zero));

  sumador_pipe_param #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(v1), .out_ready(out_ready), .sum(sum1),
    .carry_out(c1), .overflow(o1), .zero(z1));

  sumador_pipe_param #(.WIDTH(8), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .carry_in(carry_in), .sub(sub),
    .out_valid(v8), .out_ready(out_ready), .sum(sum8),
    .carry_out(c8), .overflow(o8), .zero(z8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated beat through the 32/4 DUT; also checks the 32/1 copy.
  task automatic run1(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic vc, input logic vs, input logic [31:0] es,
                      input logic ec, input logic eo, input logic ez);
    in_valid = 1'b1; a = va; b = vb; carry_in = vc; sub = vs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk({tag, "_s1v"}, v1, 1'b1);
    chk({tag, "_s1sum"}, sum1, es);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_early"}, out_valid, 1'b0);
    @(posedge clk); #2;
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"}, carry_out, ec);
    chk({tag, "_ov"}, overflow, eo);
    chk({tag, "_z"}, zero, ez);
  endtask

  task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic vs, input logic [7:0] es,
                      input logic ec, input logic eo, input logic ez);
    in_valid = 1'b1; a = {24'h0, va}; b = {24'h0, vb}; carry_in = 1'b0; sub = vs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk({tag, "_early"}, v8, 1'b0);
    @(posedge clk); #2;
    chk({tag, "_vld"}, v8, 1'b1);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_co"}, c8, ec);
    chk({tag, "_ov"}, o8, eo);
    chk({tag, "_z"}, z8, ez);
  endtask

  // Streams n beats a=i, b=i<<16; out_ready drops for 3 cycles from stall_at.
  task automatic stream(input int n, input int stall_at);
    logic [31:0] q[$];
    logic [31:0] held, exp_v;
    int sent = 0, got = 0, first = -1, last = -1;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      in_valid  = (sent < n);
      a         = sent + 1;
      b         = (sent + 1) << 16;
      carry_in  = 1'b0;
      sub       = 1'b0;
      out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
      #1;
      if (!out_ready) begin
        chk("bp_rdy", in_ready, 1'b0);
        if (cyc == stall_at) held = sum;
        else chk("bp_hold", sum, held);
      end else if (in_valid) begin
        chk("st_rdy", in_ready, 1'b1);
      end
      if (in_valid && in_ready) begin
        q.push_back((sent + 1) * 32'h0001_0001);
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        chk("st_data", sum, exp_v);
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("st_cnt", got, n);
    chk("st_left", q.size(), 0);
    if (stall_at >= 40) chk("st_contig", last - first, n - 1);
  endtask

  initial begin
    int stale;
    // Reset with garbage on the inputs.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = $urandom; b = $urandom; carry_in = 1'b1; sub = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_co", carry_out, 1'b0);
    chk("rst_ov", overflow, 1'b0);
    chk("rst_z", zero, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_v1", v1, 1'b0);
    chk("rst_v8", v8, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", in_ready, 1'b1);

    run1("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run1("sub57", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run1("subbin", 32'hA, 32'h3, 1'b1, 1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    run1("addcin", 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
    run1("sub00", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef SUMADOR_SAT_EN
    run1("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run1("negovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
    run1("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run1("negovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif

    @(posedge clk); #1;
    stream(8, 100);
    stream(10, 6);

    // Let the 8-stage copy drain before checking it directly.
    repeat (10) @(posedge clk);
    #1;
    run8("w8carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run8("w8sub", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
`ifdef SUMADOR_SAT_EN
    run8("w8ovf", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
`else
    run8("w8ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
`endif

    // Mid-flight asynchronous reset with three beats in the pipes.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h11 * (i + 1); b = 32'h100 * (i + 1);
      carry_in = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("mf_pre_v", out_valid, 1'b0);
    chk("mf_pre_v1", v1, 1'b1);
    chk("mf_pre_s1", sum1, 32'h333);
    #1 rst_n = 1'b0;
    #1;
    chk("mf_vld", out_valid, 1'b0);
    chk("mf_sum", sum, 32'h0);
    chk("mf_co", carry_out, 1'b0);
    chk("mf_ov", overflow, 1'b0);
    chk("mf_z", zero, 1'b0);
    chk("mf_rdy", in_ready, 1'b0);
    chk("mf_v1", v1, 1'b0);
    chk("mf_s1", sum1, 32'h0);
    chk("mf_v8", v8, 1'b0);
    chk("mf_s8", sum8, 8'h0);
    #1 rst_n = 1'b1;
    #1;
    chk("mf_rel_rdy", in_ready, 1'b1);
    stale = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (out_valid || v1 || v8) stale++;
    end
    chk("mf_stale", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
